// File: rtl/mult_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult_div_unit                                                               |
// | E-stage MIPS multiply/divide: HI/LO ownership and multi-cycle busy timing.  |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ISMULTDIV,
   input  logic [2:0]  MULTSel,
   input  logic        KILL,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        BUSY,
   output logic        START,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] RES
);

   localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
   localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES);
   localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

   logic [c_cnt_w-1:0] r_cnt;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;
   logic [31:0]        r_hi_t;
   logic [31:0]        r_lo_t;
   logic               r_upd;

   logic        w_busy;
   logic        w_start;
   logic        w_mt;
   logic        w_is_div;
   logic        w_is_unsigned;
   logic [63:0] w_a_ext;
   logic [63:0] w_b_ext;
   logic [63:0] w_prod;
   logic        w_neg_a;
   logic        w_neg_b;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_den;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_q;
   logic [31:0] w_r;
   logic        w_div_zero;
   logic [31:0] w_hi_next;
   logic [31:0] w_lo_next;

   assign w_busy        = (r_cnt != '0);
   assign w_is_div      = MULTSel[1];
   assign w_is_unsigned = MULTSel[0];
   assign w_start       = ISMULTDIV & MULTSel[2] & ~w_busy & ~KILL;
   assign w_mt          = ISMULTDIV & ~MULTSel[2] & MULTSel[0] & ~w_busy & ~KILL;

   // Sign-extend only for the signed variant; the low 64 bits of the product are then
   // correct for both mult and multu, so one multiplier serves both.
   assign w_a_ext = {{32{A[31] & ~w_is_unsigned}}, A};
   assign w_b_ext = {{32{B[31] & ~w_is_unsigned}}, B};
   assign w_prod  = w_a_ext * w_b_ext;

   // Signed division is done on magnitudes so 0x80000000 / -1 needs no special case.
   assign w_neg_a    = ~w_is_unsigned & A[31];
   assign w_neg_b    = ~w_is_unsigned & B[31];
   assign w_a_mag    = w_neg_a ? (~A + 32'd1) : A;
   assign w_b_mag    = w_neg_b ? (~B + 32'd1) : B;
   assign w_div_zero = (B == 32'd0);
   assign w_den      = w_div_zero ? 32'd1 : w_b_mag;
   assign w_q_mag    = w_a_mag / w_den;
   assign w_r_mag    = w_a_mag % w_den;
   assign w_q        = (w_neg_a ^ w_neg_b) ? (~w_q_mag + 32'd1) : w_q_mag;
   assign w_r        = w_neg_a ? (~w_r_mag + 32'd1) : w_r_mag;

   assign w_hi_next = w_is_div ? w_r : w_prod[63:32];
   assign w_lo_next = w_is_div ? w_q : w_prod[31:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_hi_t <= '0;
         r_lo_t <= '0;
         r_upd  <= 1'b0;
      end else if (w_start) begin
         r_cnt  <= w_is_div ? c_div_load : c_mult_load;
         r_hi_t <= w_hi_next;
         r_lo_t <= w_lo_next;
         r_upd  <= ~(w_is_div & w_div_zero);
      end else if (w_busy) begin
         r_cnt  <= r_cnt - c_cnt_one;
      end
   end

   // Completion and mthi/mtlo are mutually exclusive: the latter requires ~BUSY.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if ((r_cnt == c_cnt_one) && r_upd) begin
         r_hi <= r_hi_t;
         r_lo <= r_lo_t;
      end else if (w_mt) begin
         if (MULTSel[1]) begin
            r_lo <= A;
         end else begin
            r_hi <= A;
         end
      end
   end

   assign BUSY  = w_busy;
   assign START = w_start;
   assign HI    = r_hi;
   assign LO    = r_lo;
   assign RES   = MULTSel[1] ? r_lo : r_hi;

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

E-stage multiply/divide unit of the five-stage MIPS pipeline. It consumes the decoder's `MULTSel`/`ISMULTDIV` control for the instruction in E together with the forwarded rs/rt operands. It owns the HI/LO registers and models multi-cycle multiply/divide latency with a busy counter. It also drives the stall term that holds any later mult/div-class instruction in D.

## Interface

Parameters:
- `MULT_CYCLES`, 5: busy cycles for mult/multu (≥1)
- `DIV_CYCLES`, 10: busy cycles for div/divu (≥1)

Ports:
- `clk`  in  1  pipeline clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `ISMULTDIV`  in  1  instruction in E is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- `MULTSel`  in  3  {funct[3], funct[1:0]}:
  - 100 mult, 101 multu, 110 div, 111 divu
  - 000 mfhi, 010 mflo, 001 mthi, 011 mtlo
- `KILL`  in  1  instruction in E is being cancelled (exception/interrupt flush); suppresses every state change this cycle
- `A`  in  32  forwarded rs value
- `B`  in  32  forwarded rt value
- `BUSY`  out  1  operation in flight
- `START`  out  1  combinational: a mult/div is accepted this cycle
- `HI`  out  32  HI register
- `LO`  out  32  LO register
- `RES`  out  32  combinational: `MULTSel[1]` ? LO : HI (mfhi/mflo result into E_RES)

## Operation

- `START = ISMULTDIV & MULTSel[2] & ~BUSY & ~KILL`.
- On START, compute the result from A/B immediately into shadow registers `hi_t`/`lo_t`. Load the counter with MULT_CYCLES or DIV_CYCLES.
- mult: signed 64-bit product; multu: unsigned product; {hi_t, lo_t} = product.
- div: signed division truncated toward zero.
  - lo_t = quotient; hi_t = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo_t = 0x80000000, hi_t = 0.
- divu: unsigned division; lo_t = quotient, hi_t = remainder.
- B == 0 for div/divu:
  - the busy interval runs in full;
  - HI/LO are left unchanged at completion.
- Completion: on the edge where the counter goes 1→0, HI ← hi_t and LO ← lo_t.
- mthi: HI ← A. mtlo: LO ← A. Each requires `ISMULTDIV & ~MULTSel[2] & MULTSel[0] & ~BUSY & ~KILL`.
- While BUSY, every new start or mthi/mtlo is ignored. Upstream stalls D on (START | BUSY) whenever the D-stage instruction has ISMULTDIV, so this does not occur in legal flow.
- mfhi/mflo: no state change; RES is valid every cycle.
- KILL does not affect an operation already in flight.
- Counter width is clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

## Timing

- Reset (async, reset_n low):
  - HI = LO = 0;
  - counter = 0, BUSY = 0;
  - shadow registers = 0.
- Reset asserted mid-operation aborts the operation; HI/LO stay 0 after release.
- START in cycle t:
  - BUSY = 1 for cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES);
  - BUSY = 0 in cycle t+N+1, and the new HI/LO are visible in that same cycle.
- A new START is allowed in the first cycle BUSY is low (back-to-back, no bubble).
- mthi/mtlo accepted in cycle t: HI/LO show the new value in cycle t+1.
- RES and START are purely combinational from current inputs and HI/LO. They carry no registered latency.

## Test plan

- Reset, then mult A=0xFFFFFFFE (−2), B=3:
  - START=1 in cycle 0; BUSY=1 in cycles 1–5;
  - cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA, BUSY=0.
- multu A=0xFFFFFFFF, B=2 → after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- div A=−7 (0xFFFFFFF9), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Follow with divu A=7, B=0 → HI/LO unchanged after 10 busy cycles.
- mthi A=0x12345678 in cycle t → HI=0x12345678 in t+1. Then mflo (MULTSel=010) → RES=LO. Then mfhi (000) → RES=0x12345678.
- KILL=1 with mult and ISMULTDIV=1 → START=0, BUSY stays 0, HI/LO unchanged. mtlo with KILL=1 → LO unchanged.
- div started, then reset_n pulsed low in busy cycle 4 → BUSY=0 and HI=LO=0 immediately (asynchronously), with no completion update afterwards. Separately, a mult presented while BUSY → ignored, and START=0.
